wave_capture: RTL and testbench

- Audio sample recorder; the write-side counterpart of the wave_sound DMA player.
- Decimates a 16-bit signed audio stream on I_SND to 8-bit unsigned samples at a fixed sample rate.
- Writes samples sequentially into the wave dual-port RAM, so wave_sound can play them back from address 0.
- Optional level trigger: recording starts on the first sample loud enough to pass a threshold.

---
 rtl/wave_capture.sv | 129 ++++++++++++
 tb/tb_wave_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// wave_capture: decimates a signed 16-bit audio stream to 8-bit unsigned samples and writes them into the wave RAM.
// Latency: sample tick to write strobe is 1 cycle; no backpressure, the RAM write port accepts every strobe.
module wave_capture #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DIV    = 3000,
    parameter logic [15:0] THRESH = 16'd1024
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_START,
    input  logic              I_STOP,
    input  logic              I_TRIG_EN,
    input  logic [15:0]       I_SND,
    output logic              O_WR_EN,
    output logic [ADDR_W-1:0] O_WR_ADDR,
    output logic [7:0]        O_WR_DATA,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic [ADDR_W:0]   O_LEN
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   presc;
    logic            trig_en;
    logic            tick;
    logic [15:0]     mag;
    logic            trig_hit;
    logic [7:0]      sample;
    logic            do_start;
    logic            do_wr;
    logic            do_done;

    assign tick     = (presc == PW'(DIV - 1));
    assign sample   = {~I_SND[15], I_SND[14:8]};
    assign trig_hit = (mag >= THRESH);

    // -32768 has no positive twin in 16 bits, so it saturates to 32767
    always_comb begin
        mag = I_SND;
        if (I_SND[15]) begin
            if (I_SND == 16'h8000) begin
                mag = 16'h7FFF;
            end else begin
                mag = 16'(~I_SND + 16'd1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_wr     = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: begin
                if (I_START && !I_STOP) begin
                    do_start  = 1'b1;
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (I_STOP) begin
                    state_nxt = IDLE;
                    do_done   = 1'b1;
                end else if (!trig_en) begin
                    state_nxt = CAPTURE;
                end else if (tick && trig_hit) begin
                    do_wr     = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                do_wr = tick;
                if (I_STOP) begin
                    state_nxt = IDLE;
                    do_done   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The byte count doubles as the write pointer; the last address ends the capture
        if (do_wr && (&O_LEN[ADDR_W-1:0])) begin
            state_nxt = IDLE;
            do_done   = 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            state     <= IDLE;
            presc     <= '0;
            trig_en   <= 1'b0;
            O_WR_EN   <= 1'b0;
            O_WR_ADDR <= '0;
            O_WR_DATA <= '0;
            O_BUSY    <= 1'b0;
            O_DONE    <= 1'b0;
            O_LEN     <= '0;
        end else begin
            state   <= state_nxt;
            O_BUSY  <= (state_nxt != IDLE);
            O_DONE  <= do_done;
            O_WR_EN <= do_wr;
            if (state == IDLE || state_nxt == IDLE || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            if (do_start) begin
                O_LEN   <= '0;
                trig_en <= I_TRIG_EN;
            end
            if (do_wr) begin
                O_WR_ADDR <= O_LEN[ADDR_W-1:0];
                O_WR_DATA <= sample;
                O_LEN     <= O_LEN + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture with a write scoreboard (DIV=4, ADDR_W=4, THRESH=1024).
module tb_wave_capture;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DIV    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              trig;
    logic [15:0]       snd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   len;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   n;

    wave_capture #(
        .ADDR_W (ADDR_W),
        .DIV    (DIV),
        .THRESH (16'd1024)
    ) dut (
        .I_CLK     (clk),
        .I_RSTn    (rst_n),
        .I_START   (start),
        .I_STOP    (stop),
        .I_TRIG_EN (trig),
        .I_SND     (snd),
        .O_WR_EN   (wr_en),
        .O_WR_ADDR (wr_addr),
        .O_WR_DATA (wr_data),
        .O_BUSY    (busy),
        .O_DONE    (done),
        .O_LEN     (len)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] conv(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d, input logic dn);
        exp_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        e.done = dn;
        sb_q.push_back(e);
    endtask

    // Advance one clock, then compare any write strobe against the scoreboard
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                chk("spurious_wr", 32'(wr_en), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("wr_done", 32'(done), 32'(e.done));
            end
        end
    endtask

    task automatic wait_wr(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (wr_en !== 1'b1 && cnt < 20);
        if (wr_en !== 1'b1) chk("wr_timeout", 32'(wr_en), 32'd1);
    endtask

    initial begin
        logic [15:0] s;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; trig = 1'b0; snd = 16'h0000;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_len", 32'(len), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);

        // Free-running capture to full, checking conversion extremes
        snd = 16'h8000; trig = 1'b0; start = 1'b1;
        push(0, 8'h00, 1'b0);
        cyc();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        wait_wr(n);
        chk("first_latency", 32'(n), 32'(DIV));
        snd = 16'h7FFF; push(1, 8'hFF, 1'b0);
        wait_wr(n);
        chk("gap1", 32'(n), 32'(DIV));
        snd = 16'h0000; push(2, 8'h80, 1'b0);
        wait_wr(n);
        chk("gap2", 32'(n), 32'(DIV));
        for (int i = 3; i < 16; i++) begin
            s = 16'(i * 16'h0913 + 16'h2200);
            snd = s;
            push(i, conv(s), i == 15);
            wait_wr(n);
            chk("gap_n", 32'(n), 32'(DIV));
        end
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_len", 32'(len), 32'd16);
        repeat (12) cyc();
        chk("full_count", 32'(wr_cnt), 32'd16);
        chk("full_no_wr", 32'(wr_en), 32'd0);
        chk("full_addr_hold", 32'(wr_addr), 32'd15);
        chk("full_len_hold", 32'(len), 32'd16);

        // Level trigger: three quiet ticks, then -1024 fires
        trig = 1'b1; snd = 16'd1000; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (12) cyc();
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_len", 32'(len), 32'd0);
        chk("arm_no_wr", 32'(wr_cnt), 32'd16);
        snd = 16'hFC00; push(0, 8'h7C, 1'b0);
        wait_wr(n);
        chk("trig_latency", 32'(n), 32'(DIV));
        for (int i = 1; i < 5; i++) begin
            s = 16'(16'h1000 * i + 16'h0345);
            snd = s;
            push(i, conv(s), 1'b0);
            wait_wr(n);
            chk("trig_gap", 32'(n), 32'(DIV));
        end
        // Stop lands on the sixth tick: that sample still gets written
        snd = 16'hC3A5;
        cyc(); cyc(); cyc();
        stop = 1'b1;
        push(5, conv(16'hC3A5), 1'b1);
        cyc();
        stop = 1'b0;
        chk("stop_tick_len", 32'(len), 32'd6);
        chk("stop_tick_busy", 32'(busy), 32'd0);
        cyc();
        chk("stop_done_clear", 32'(done), 32'd0);
        chk("stop_no_wr", 32'(wr_en), 32'd0);

        // Start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy), 32'd0);
        cyc();
        chk("ss_len_hold", 32'(len), 32'd6);

        // Stop while armed
        trig = 1'b1; snd = 16'h0000; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("arm2_busy", 32'(busy), 32'd1);
        chk("arm2_len", 32'(len), 32'd0);
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("arm_stop_done", 32'(done), 32'd1);
        chk("arm_stop_len", 32'(len), 32'd0);
        chk("arm_stop_busy", 32'(busy), 32'd0);
        cyc();
        chk("arm_stop_done_clr", 32'(done), 32'd0);

        // Start during capture is ignored
        trig = 1'b0; snd = 16'h1234; start = 1'b1;
        push(0, conv(16'h1234), 1'b0);
        cyc();
        start = 1'b0;
        wait_wr(n);
        chk("cap_first", 32'(n), 32'(DIV));
        snd = 16'hABCD; push(1, conv(16'hABCD), 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_wr(n);
        chk("restart_ignored", 32'(n), 32'(DIV - 1));
        chk("restart_len", 32'(len), 32'd2);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_idle_done", 32'(done), 32'd1);
        chk("stop_idle_wr", 32'(wr_en), 32'd0);
        chk("stop_idle_len", 32'(len), 32'd2);

        // Reset on the third write abandons the capture silently
        snd = 16'h5555; start = 1'b1;
        push(0, conv(16'h5555), 1'b0);
        push(1, conv(16'h5555), 1'b0);
        push(2, conv(16'h5555), 1'b0);
        cyc();
        start = 1'b0;
        wait_wr(n); wait_wr(n); wait_wr(n);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_wr", 32'(wr_en), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_len", 32'(len), 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1; snd = 16'h2000; start = 1'b1;
        push(0, 8'hA0, 1'b0);
        cyc();
        start = 1'b0;
        chk("post_rst_len0", 32'(len), 32'd0);
        wait_wr(n);
        chk("post_rst_lat", 32'(n), 32'(DIV));
        chk("post_rst_len1", 32'(len), 32'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
